execute_stage: RTL

Execute stage of the 5-stage RISC-V integer pipeline: it holds the ID/EX pipeline register, forwards operands, computes the ALU result and resolves branches/jumps, and drives the EX/MEM pipeline register. It sits between decode and the memory stage. Its 4-bit ALU operation encoding is the one used by the integer ALU: add, sub, and, or, xor, slt, sll, srl, sltu, sra.

---
 rtl/execute_stage.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/execute_stage.sv
// RV32I execute stage: ID/EX register, operand forwarding, ALU, branch/jump
// resolution and the EX/MEM register feeding the memory stage.
module execute_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            id_valid,
   input  logic [XLEN-1:0] id_pc,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic [XLEN-1:0] id_imm,
   input  logic [4:0]      id_rs1,
   input  logic [4:0]      id_rs2,
   input  logic [4:0]      id_rd,
   input  logic [3:0]      id_alu_ctrl,
   input  logic [2:0]      id_funct3,
   input  logic [7:0]      id_ctrl,
   input  logic            stall,
   input  logic            flush,
   input  logic            wb_fwd_we,
   input  logic [4:0]      wb_fwd_rd,
   input  logic [XLEN-1:0] wb_fwd_data,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            ex_valid,
   output logic [XLEN-1:0] ex_result,
   output logic [XLEN-1:0] ex_store_data,
   output logic [4:0]      ex_rd,
   output logic            ex_reg_write,
   output logic            ex_mem_read,
   output logic            ex_mem_write
);

   logic            e_valid_q;
   logic [XLEN-1:0] e_pc_q, e_rs1_data_q, e_rs2_data_q, e_imm_q;
   logic [4:0]      e_rs1_q, e_rs2_q, e_rd_q;
   logic [3:0]      e_alu_q;
   logic [2:0]      e_funct3_q;
   logic [7:0]      e_ctrl_q;

   logic            ex_valid_q, ex_reg_write_q, ex_mem_read_q, ex_mem_write_q;
   logic [XLEN-1:0] ex_result_q, ex_store_data_q;
   logic [4:0]      ex_rd_q;

   logic            c_jalr, c_jal, c_branch, c_mem_write, c_mem_read, c_reg_write, c_src_b_imm, c_src_a_pc;
   logic [XLEN-1:0] fwd_rs1, fwd_rs2, op_a, op_b, alu_res, jalr_sum;
   logic [XLEN-1:0] ex_result_d;
   logic            br_cond;

   assign {c_jalr, c_jal, c_branch, c_mem_write, c_mem_read, c_reg_write, c_src_b_imm, c_src_a_pc} = e_ctrl_q;

   // A load in EX/MEM has no data yet, so it never forwards; the hazard unit stalls instead.
   always_comb begin
      fwd_rs1 = e_rs1_data_q;
      if (ex_valid_q && ex_reg_write_q && !ex_mem_read_q && ex_rd_q == e_rs1_q && e_rs1_q != 5'd0)
         fwd_rs1 = ex_result_q;
      else if (wb_fwd_we && wb_fwd_rd == e_rs1_q && e_rs1_q != 5'd0)
         fwd_rs1 = wb_fwd_data;
   end

   always_comb begin
      fwd_rs2 = e_rs2_data_q;
      if (ex_valid_q && ex_reg_write_q && !ex_mem_read_q && ex_rd_q == e_rs2_q && e_rs2_q != 5'd0)
         fwd_rs2 = ex_result_q;
      else if (wb_fwd_we && wb_fwd_rd == e_rs2_q && e_rs2_q != 5'd0)
         fwd_rs2 = wb_fwd_data;
   end

   assign op_a = c_src_a_pc  ? e_pc_q  : fwd_rs1;
   assign op_b = c_src_b_imm ? e_imm_q : fwd_rs2;

   always_comb begin
      alu_res = '0;
      case (e_alu_q)
         4'b0000: alu_res = op_a + op_b;
         4'b0001: alu_res = op_a - op_b;
         4'b0010: alu_res = op_a & op_b;
         4'b0011: alu_res = op_a | op_b;
         4'b0100: alu_res = op_a ^ op_b;
         4'b0101: alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
         4'b0110: alu_res = op_a << op_b[4:0];
         4'b0111: alu_res = op_a >> op_b[4:0];
         4'b1000: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
         4'b1001: alu_res = $signed(op_a) >>> op_b[4:0];
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      br_cond = 1'b0;
      case (e_funct3_q)
         3'b000:  br_cond = fwd_rs1 == fwd_rs2;
         3'b001:  br_cond = fwd_rs1 != fwd_rs2;
         3'b100:  br_cond = $signed(fwd_rs1) <  $signed(fwd_rs2);
         3'b101:  br_cond = $signed(fwd_rs1) >= $signed(fwd_rs2);
         3'b110:  br_cond = fwd_rs1 <  fwd_rs2;
         3'b111:  br_cond = fwd_rs1 >= fwd_rs2;
         default: br_cond = 1'b0;
      endcase
   end

   assign jalr_sum       = fwd_rs1 + e_imm_q;
   assign redirect_valid = e_valid_q && !stall && (c_jal || c_jalr || (c_branch && br_cond));
   assign redirect_pc    = c_jalr ? (jalr_sum & ~XLEN'(1)) : (e_pc_q + e_imm_q);
   assign ex_result_d    = (c_jal || c_jalr) ? (e_pc_q + XLEN'(4)) : alu_res;

   // ID/EX: a redirect squashes whatever decode is presenting this cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         e_valid_q    <= 1'b0;
         e_pc_q       <= '0;
         e_rs1_data_q <= '0;
         e_rs2_data_q <= '0;
         e_imm_q      <= '0;
         e_rs1_q      <= '0;
         e_rs2_q      <= '0;
         e_rd_q       <= '0;
         e_alu_q      <= '0;
         e_funct3_q   <= '0;
         e_ctrl_q     <= '0;
      end else if (flush || redirect_valid) begin
         e_valid_q <= 1'b0;
      end else if (!stall) begin
         e_valid_q    <= id_valid;
         e_pc_q       <= id_pc;
         e_rs1_data_q <= id_rs1_data;
         e_rs2_data_q <= id_rs2_data;
         e_imm_q      <= id_imm;
         e_rs1_q      <= id_rs1;
         e_rs2_q      <= id_rs2;
         e_rd_q       <= id_rd;
         e_alu_q      <= id_alu_ctrl;
         e_funct3_q   <= id_funct3;
         e_ctrl_q     <= id_ctrl;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid_q      <= 1'b0;
         ex_reg_write_q  <= 1'b0;
         ex_mem_read_q   <= 1'b0;
         ex_mem_write_q  <= 1'b0;
         ex_result_q     <= '0;
         ex_store_data_q <= '0;
         ex_rd_q         <= '0;
      end else if (stall || !e_valid_q) begin
         ex_valid_q     <= 1'b0;
         ex_reg_write_q <= 1'b0;
         ex_mem_read_q  <= 1'b0;
         ex_mem_write_q <= 1'b0;
      end else begin
         ex_valid_q      <= 1'b1;
         ex_reg_write_q  <= c_reg_write && (e_rd_q != 5'd0);
         ex_mem_read_q   <= c_mem_read;
         ex_mem_write_q  <= c_mem_write;
         ex_result_q     <= ex_result_d;
         ex_store_data_q <= fwd_rs2;
         ex_rd_q         <= e_rd_q;
      end
   end

   assign ex_valid      = ex_valid_q;
   assign ex_result     = ex_result_q;
   assign ex_store_data = ex_store_data_q;
   assign ex_rd         = ex_rd_q;
   assign ex_reg_write  = ex_reg_write_q;
   assign ex_mem_read   = ex_mem_read_q;
   assign ex_mem_write  = ex_mem_write_q;

endmodule
